// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port among NREQ requesters using aged-priority
// round-robin arbitration. A grant runs one transfer of one or two words; the
// second word's address is derived here, so requesters never drive RAM directly.

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int         NREQ         = 4,
    parameter logic [7:0] PRIO         = 8'b0000_0101,
    parameter int         STARVE_LIMIT = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wen,
    input  logic [NREQ-1:0]      burst,
    input  logic [NREQ*32-1:0]   addr,
    input  logic [NREQ*32-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  ramstate_t            ramstate
);

    localparam int              IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]      AGE_MAX = 4'(STARVE_LIMIT);
    localparam logic [IW-1:0]   LAST    = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_rr_ptr;
    logic [IW-1:0]          w_winner;
    logic [IW-1:0]          w_rr_nxt;
    logic [NREQ-1:0][3:0]   r_age;
    logic [NREQ-1:0]        w_promo;
    logic [NREQ-1:0]        w_high;
    logic [NREQ-1:0]        w_low;
    logic [NREQ-1:0]        w_tier;
    logic                   w_arb;
    logic                   w_own_req;
    logic                   w_own_wen;
    logic                   w_own_burst;
    logic [31:0]            w_own_addr;
    logic [31:0]            w_own_wdata;

    // First set bit of mask at or after ptr, wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && mask[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Sort requesters into tiers and choose the round-robin winner of the top non-empty tier.
    always_comb begin
        w_promo = '0;
        w_high  = '0;
        w_low   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (r_age[i] == AGE_MAX)) begin
                w_promo[i] = 1'b1;
            end else if (req[i] && PRIO[i]) begin
                w_high[i] = 1'b1;
            end else if (req[i]) begin
                w_low[i] = 1'b1;
            end else begin
                w_low[i] = 1'b0;
            end
        end
        if (|w_promo) begin
            w_tier = w_promo;
        end else if (|w_high) begin
            w_tier = w_high;
        end else begin
            w_tier = w_low;
        end
        w_winner = rr_pick(w_tier, r_rr_ptr);
        if (w_winner == LAST) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = w_winner + IW'(1);
        end
        w_arb = (r_state == S_IDLE) && (|req);
    end

    // Fields belonging to the current owner.
    always_comb begin
        w_own_req   = req[r_owner];
        w_own_wen   = wen[r_owner];
        w_own_burst = burst[r_owner];
        w_own_addr  = addr[32*int'(r_owner) +: 32];
        w_own_wdata = wdata[32*int'(r_owner) +: 32];
    end

    // Next state and Mealy outputs; retry simply holds the beat until RAM reports ACCESS.
    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        rdata       = 32'h0;
        gnt         = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'h0;
        ramstore    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_BEAT0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BEAT0, S_BEAT1: begin
                gnt[r_owner] = 1'b1;
                ramstore     = w_own_wdata;
                if (r_state == S_BEAT1) begin
                    ramaddr = w_own_addr + 32'd4;
                end else begin
                    ramaddr = w_own_addr;
                end
                if (!w_own_req) begin
                    // Withdrawn: enables stay low, no ack, back to IDLE.
                    w_state_nxt = S_IDLE;
                end else begin
                    ramREN = ~w_own_wen;
                    ramWEN = w_own_wen;
                    if (ramstate == ACCESS) begin
                        ack[r_owner] = 1'b1;
                        if (!w_own_wen) begin
                            rdata = ramload;
                        end else begin
                            rdata = 32'h0;
                        end
                        if ((r_state == S_BEAT0) && w_own_burst) begin
                            w_state_nxt = S_BEAT1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) begin
                r_owner  <= w_winner;
                r_rr_ptr <= w_rr_nxt;
            end
        end
    end

    // Age counters: clear when not requesting, otherwise age on each lost arbitration.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_age <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    r_age[i] <= 4'd0;
                end else if (w_arb) begin
                    if (w_winner == IW'(i)) begin
                        r_age[i] <= 4'd0;
                    end else if (r_age[i] < AGE_MAX) begin
                        r_age[i] <= r_age[i] + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level arbitration model. The bench also plays the RAM.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int          N        = 4;
    localparam int          LIM      = 3;
    localparam logic [3:0]  TB_PRIO  = 4'b0101;
    localparam logic [31:0] LOAD_KEY = 32'hC3A5_0F1E;

    logic           CLK = 1'b0;
    logic           nRST = 1'b0;
    logic [3:0]     req = '0, wen = '0, burst = '0;
    logic [127:0]   addr = '0, wdata = '0;
    logic [3:0]     ack, gnt;
    logic [31:0]    rdata, ramaddr, ramstore, ramload;
    logic           ramREN, ramWEN;
    ramstate_t      ramstate;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ws       = 0;
    int   ram_cnt  = 0;
    logic force_err = 1'b0;
    logic [31:0] mem [1024];

    // Arbitration model and random requester state
    int          m_age [N];
    int          m_ptr;
    bit          m_busy, m_beat;
    int          m_owner, m_wait;
    logic [3:0]  pend, t_wen, t_burst, t_b1;
    logic [31:0] t_addr [N];
    logic [31:0] t_w0 [N];
    logic [31:0] t_w1 [N];

    ram_arbiter #(.NREQ(4), .PRIO(8'b0000_0101), .STARVE_LIMIT(3)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .burst(burst),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .gnt(gnt),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM read port returns an address-derived pattern
    assign ramload = ramaddr ^ LOAD_KEY;

    // RAM status: ACCESS after ws wait cycles of an active access
    always_comb begin
        if (force_err)               ramstate = ERROR;
        else if (ramREN || ramWEN)   ramstate = (ram_cnt == ws) ? ACCESS : BUSY;
        else                         ramstate = FREE;
    end

    // RAM wait counter and write storage
    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && (ramstate != ACCESS)) ram_cnt <= ram_cnt + 1;
        else                                            ram_cnt <= 0;
        if (ramWEN && (ramstate == ACCESS)) mem[ramaddr[11:2]] <= ramstore;
    end

    function automatic int model_pick(input logic [3:0] r);
        int best, best_key, key, tier;
        best = -1;
        best_key = 1000;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                tier = (m_age[i] == LIM) ? 0 : (TB_PRIO[i] ? 1 : 2);
                key  = tier * 10 + ((i - m_ptr + N) % N);
                if (key < best_key) begin
                    best_key = key;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_grant(input logic [3:0] r, input int w);
        for (int i = 0; i < N; i++)
            m_age[i] = (r[i] && i != w) ? ((m_age[i] < LIM) ? m_age[i] + 1 : LIM) : 0;
        m_ptr = (w + 1) % N;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_ptr = 0;
    endtask

    task automatic do_reset();
        nRST = 1'b0; req = '0; wen = '0; burst = '0; addr = '0; wdata = '0;
        ws = 0; force_err = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; req = 4'b1111; wen = 4'b0101; addr = {4{32'h1234_5670}};
        wdata = {4{32'hDEAD_BEEF}};
        @(negedge CLK); #1;
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_checks++; if ({ramREN, ramWEN} !== 2'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=00", {ramREN, ramWEN}); end
        n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
        n_checks++; if (ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_ramstore got=%h exp=0", ramstore); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge CLK);
        req = 4'b0100; addr[64 +: 32] = 32'h100; ws = 0;
        #1;
        n_checks++; if ({gnt, ramREN} !== 5'b0) begin n_fail++; $display("FAIL single_c0 got gnt=%b ren=%b exp 0000 0", gnt, ramREN); end
        @(negedge CLK); #1;
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, ack, gnt, rdata} !== {1'b1, 1'b0, 32'h100, 4'b0100, 4'b0100, 32'h100 ^ LOAD_KEY}) begin
            n_fail++;
            $display("FAIL single_c1 got ren=%b wen=%b addr=%h ack=%b gnt=%b rdata=%h exp 1 0 100 0100 0100 %h",
                     ramREN, ramWEN, ramaddr, ack, gnt, rdata, 32'h100 ^ LOAD_KEY);
        end
        @(negedge CLK); req = '0; #1;
        n_checks++; if ({gnt, ack, ramREN} !== 9'b0) begin n_fail++; $display("FAIL single_c2 got gnt=%b ack=%b ren=%b exp zeros", gnt, ack, ramREN); end
    endtask

    task automatic test_write_burst();
        logic [31:0] q[$];
        int n_acks;
        do_reset();
        @(negedge CLK);
        req = 4'b0010; wen = 4'b0010; burst = 4'b0010; ws = 2;
        addr[32 +: 32] = 32'hFFC; wdata[32 +: 32] = 32'hA;
        n_acks = 0;
        for (int c = 0; c < 20 && n_acks < 2; c++) begin
            #1;
            if (ramWEN) q.push_back(ramaddr);
            if (ack[1]) n_acks++;
            @(negedge CLK);
            if (n_acks == 1) wdata[32 +: 32] = 32'hB;
            if (n_acks == 2) req = '0;
        end
        #1;
        n_checks++; if (n_acks != 2) begin n_fail++; $display("FAIL burst_acks got=%0d exp=2", n_acks); end
        n_checks++; if (q.size() != 6) begin n_fail++; $display("FAIL burst_addr_cycles got=%0d exp=6", q.size()); end
        if (q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (q[k] !== ((k < 3) ? 32'hFFC : 32'h1000)) begin
                    n_fail++; $display("FAIL burst_addr[%0d] got=%h exp=%h", k, q[k], (k < 3) ? 32'hFFC : 32'h1000);
                end
            end
        end
        n_checks++; if (mem[1023] !== 32'hA) begin n_fail++; $display("FAIL burst_mem0 got=%h exp=a", mem[1023]); end
        n_checks++; if (mem[0] !== 32'hB) begin n_fail++; $display("FAIL burst_mem1 got=%h exp=b", mem[0]); end
        n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL burst_extra_ack got=%b exp=0000", ack); end
    endtask

    task automatic test_round_robin();
        int exp_rr [6] = '{0, 2, 0, 2, 0, 2};
        int k, prev_c;
        logic [3:0] e_ack;
        do_reset();
        @(negedge CLK);
        req = 4'b0101; ws = 0; addr = {32'h30, 32'h20, 32'h10, 32'h0};
        k = 0; prev_c = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            #1;
            if (ack != 4'b0) begin
                e_ack = 4'b0001 << exp_rr[k];
                n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, ack, e_ack); end
                if (k > 0) begin
                    n_checks++; if (c - prev_c != 2) begin n_fail++; $display("FAIL rr_spacing[%0d] got=%0d exp=2", k, c - prev_c); end
                end
                prev_c = c;
                k++;
            end
            @(negedge CLK);
        end
        n_checks++; if (k != 6) begin n_fail++; $display("FAIL rr_timeout got=%0d grants exp=6", k); end
        req = '0;
    endtask

    task automatic test_starvation();
        int k, w;
        logic [3:0] e_ack;
        do_reset();
        model_clear();
        @(negedge CLK);
        req = 4'b0111; ws = 0; addr = {32'h30, 32'h20, 32'h10, 32'h0};
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            #1;
            if (ack != 4'b0) begin
                w = model_pick(4'b0111);
                model_grant(4'b0111, w);
                e_ack = 4'b0001 << w;
                n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL starve_grant[%0d] got=%b exp=%b", k, ack, e_ack); end
                if (k == 3) begin
                    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL starve_promoted got=%b exp=0010", ack); end
                end
                k++;
            end
            @(negedge CLK);
        end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL starve_timeout got=%0d grants exp=8", k); end
        req = '0;
    endtask

    task automatic test_withdraw_retry();
        do_reset();
        @(negedge CLK);
        req = 4'b1000; addr[96 +: 32] = 32'h40; ws = 0; force_err = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); #1;
            n_checks++;
            if ({gnt, ack, ramREN, ramWEN, ramaddr} !== {4'b1000, 4'b0000, 1'b1, 1'b0, 32'h40}) begin
                n_fail++;
                $display("FAIL retry_hold[%0d] got gnt=%b ack=%b ren=%b wen=%b addr=%h exp 1000 0000 1 0 40",
                         c, gnt, ack, ramREN, ramWEN, ramaddr);
            end
        end
        @(negedge CLK); req = '0; force_err = 1'b0; #1;
        n_checks++; if ({ack, ramREN, ramWEN} !== 6'b0) begin n_fail++; $display("FAIL withdraw_en got ack=%b ren=%b wen=%b exp zeros", ack, ramREN, ramWEN); end
        @(negedge CLK); #1;
        n_checks++; if ({gnt, ack, ramREN} !== 9'b0) begin n_fail++; $display("FAIL withdraw_idle got gnt=%b ack=%b ren=%b exp zeros", gnt, ack, ramREN); end
    endtask

    task automatic test_async_reset();
        int c;
        do_reset();
        @(negedge CLK);
        req = 4'b0010; burst = 4'b0010; addr[32 +: 32] = 32'h200; ws = 0;
        @(negedge CLK);
        @(negedge CLK); #1;
        n_checks++;
        if ({ramREN, ramaddr, ack} !== {1'b1, 32'h204, 4'b0010}) begin
            n_fail++; $display("FAIL areset_beat1 got ren=%b addr=%h ack=%b exp 1 204 0010", ramREN, ramaddr, ack);
        end
        #1 nRST = 1'b0;
        #1;
        n_checks++;
        if ({gnt, ack, ramREN, ramWEN, ramaddr, ramstore, rdata} !== 106'b0) begin
            n_fail++; $display("FAIL areset_outputs got gnt=%b ack=%b ren=%b wen=%b addr=%h store=%h rdata=%h exp zeros",
                               gnt, ack, ramREN, ramWEN, ramaddr, ramstore, rdata);
        end
        @(negedge CLK);
        nRST = 1'b1; req = 4'b1010; burst = '0; addr[96 +: 32] = 32'h300;
        c = 0;
        while (ack == 4'b0 && c < 10) begin
            @(negedge CLK); #1;
            c++;
        end
        n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL areset_first_grant got=%b exp=0010", ack); end
        req = '0;
    endtask

    task automatic test_random();
        logic [3:0]  cur_req, e_gnt, e_ack;
        logic        e_ren, e_wen, acc;
        logic [31:0] e_addr, e_store, e_rdata;
        int g, w;
        do_reset();
        model_clear();
        m_busy = 0; m_beat = 0; m_wait = 0; m_owner = 0;
        pend = '0; t_b1 = '0; t_wen = '0; t_burst = '0;
        for (int i = 0; i < N; i++) begin t_addr[i] = 32'h0; t_w0[i] = 32'h0; t_w1[i] = 32'h0; end
        g = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 25)) begin
                    pend[i]    = 1'b1;
                    t_wen[i]   = 1'($urandom_range(0, 1));
                    t_burst[i] = 1'($urandom_range(0, 1));
                    t_addr[i]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
                    t_w0[i]    = $urandom();
                    t_w1[i]    = $urandom();
                    t_b1[i]    = 1'b0;
                end
                req[i]   = pend[i];
                wen[i]   = t_wen[i];
                burst[i] = t_burst[i];
                addr[i*32 +: 32]  = t_addr[i];
                wdata[i*32 +: 32] = t_b1[i] ? t_w1[i] : t_w0[i];
            end
            if (!m_busy) ws = $urandom_range(0, 2);
            #1;
            cur_req = req;
            e_gnt = '0; e_ack = '0; e_ren = 1'b0; e_wen = 1'b0;
            e_addr = '0; e_store = '0; e_rdata = '0; acc = 1'b0;
            if (m_busy) begin
                g       = m_owner;
                e_gnt   = 4'b0001 << g;
                e_addr  = m_beat ? t_addr[g] + 32'd4 : t_addr[g];
                e_store = t_b1[g] ? t_w1[g] : t_w0[g];
                e_ren   = ~t_wen[g];
                e_wen   = t_wen[g];
                acc     = (m_wait == ws);
                if (acc) begin
                    e_ack   = e_gnt;
                    e_rdata = t_wen[g] ? 32'h0 : e_addr ^ LOAD_KEY;
                end
            end
            n_checks++;
            if ({gnt, ack, ramREN, ramWEN, ramaddr, ramstore, rdata} !== {e_gnt, e_ack, e_ren, e_wen, e_addr, e_store, e_rdata}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got gnt=%b ack=%b ren=%b wen=%b addr=%h store=%h rdata=%h exp gnt=%b ack=%b ren=%b wen=%b addr=%h store=%h rdata=%h",
                         cyc, gnt, ack, ramREN, ramWEN, ramaddr, ramstore, rdata,
                         e_gnt, e_ack, e_ren, e_wen, e_addr, e_store, e_rdata);
            end
            if (m_busy) begin
                for (int i = 0; i < N; i++) if (!cur_req[i]) m_age[i] = 0;
                if (acc) begin
                    if (!m_beat && t_burst[g]) begin
                        m_beat = 1; m_wait = 0; t_b1[g] = 1'b1;
                    end else begin
                        m_busy = 0; pend[g] = 1'b0;
                    end
                end else begin
                    m_wait++;
                end
            end else if (cur_req != 4'b0) begin
                w = model_pick(cur_req);
                model_grant(cur_req, w);
                m_busy = 1; m_owner = w; m_beat = 0; m_wait = 0;
            end else begin
                for (int i = 0; i < N; i++) m_age[i] = 0;
            end
        end
        req = '0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_round_robin();
        test_starvation();
        test_withdraw_retry();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single RAM port between NREQ requesters: the instruction and data ports of both CPUs, or the coherence controller plus other bus masters. It sits directly in front of the RAM model and performs aged-priority round-robin arbitration. Each grant runs one transfer of one or two words, with the address of the second word generated internally. It owns the RAM enables and address mux, so requesters never drive RAM directly.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- PRIO, 4'b0101, bit i = 1 puts requester i in the high class
- STARVE_LIMIT, 8, number of lost grants before a waiting requester is promoted (1..15)

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- req  in  NREQ  request, held until final ack or intentionally withdrawn
- wen  in  NREQ  1 = write, 0 = read, per requester
- burst  in  NREQ  1 = two-word transfer, 0 = single word
- addr  in  NREQ*32  word-aligned base address, slice i = bits [32i+31:32i]
- wdata  in  NREQ*32  write data for the current beat
- ack  out  NREQ  one-cycle pulse per completed beat
- rdata  out  32  read data, valid only while the matching ack is high
- gnt  out  NREQ  one-hot current owner, all zeros when idle
- ramREN, ramWEN  out  1 each  RAM enables
- ramaddr, ramstore  out  32 each  RAM address and write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  RAM status (FREE/BUSY/ACCESS/ERROR) from cpu_types_pkg

## Operation
- States: IDLE, BEAT0, BEAT1.
- IDLE:
  - If any req is high, select a winner, register the owner, and go to BEAT0.
  - If no req is high, stay in IDLE.
- Winner selection, strict tier order:
  1. Promoted requesters (age counter == STARVE_LIMIT).
  2. High-class requesters (PRIO bit set).
  3. Low-class requesters.
- Within a tier, round-robin: search starts at index rr_ptr and wraps modulo NREQ.
- On each grant, rr_ptr becomes (winner + 1) mod NREQ.
- BEAT0 / BEAT1 (owner g):
  - ramREN = ~wen[g], ramWEN = wen[g], ramstore = wdata[g], gnt = one-hot g.
  - ramaddr = addr[g] in BEAT0, addr[g] + 4 in BEAT1 (32-bit add, wraps at 2^32).
  - ramstate == ACCESS: pulse ack[g]; for reads, rdata = ramload in that cycle.
  - After the BEAT0 ack: go to BEAT1 if burst[g] is set, else to IDLE.
  - After the BEAT1 ack: go to IDLE.
  - ramstate BUSY, FREE or ERROR: hold the state and drive identical outputs (retry).
- Withdrawal: if req[g] is low during a beat, drive RAM enables to 0, give no ack, and return to IDLE next cycle. A completed BEAT0 is not undone.
- Requester contract:
  - Hold wen, burst and addr stable for the whole grant.
  - For a write burst, change wdata to the second word after the first ack.
- Age counters, one 4-bit counter per requester, updated on each grant in IDLE:
  - Increment (saturating at STARVE_LIMIT) if req[i] is high and i is not the winner.
  - Clear to 0 if i is the winner, or whenever req[i] is low.
- Defaults whenever not in a beat: ack = 0, rdata = 0, ramREN = ramWEN = 0, ramaddr = ramstore = 0, gnt = 0.

## Timing
- Reset values: state IDLE, rr_ptr 0, all age counters 0, all outputs 0.
- Reset mid-transfer aborts immediately. No ack is issued and RAM enables drop asynchronously.
- Arbitration latency: req high in IDLE at cycle n puts RAM enables on the bus at cycle n+1 at the earliest.
- Each beat lasts as many cycles as RAM takes to report ACCESS; with zero wait states, 1 cycle.
- There is one IDLE bubble cycle between consecutive grants, including back-to-back requests from the same requester.
- Best-case single read: req at cycle 0, ack at cycle 1, IDLE at cycle 2.
- Best-case burst: acks at cycles 1 and 2.
- Simultaneous requests are resolved only in IDLE. A request arriving mid-grant waits and ages at the next grant.
- ack, rdata and ram* outputs are combinational from state and the current ramstate/ramload (Mealy outputs).

## Test plan
- Single read, zero wait states: req[2]=1, addr=0x100, burst=0 → cycle 1 ramREN=1, ramaddr=0x100, ack[2]=1, rdata=ramload; cycle 2 gnt=0.
- Write burst with 2 wait states: req[1]=1, wen=1, burst=1, addr=0xFFC, wdata 0xA then 0xB after first ack → ramaddr 0xFFC for 3 cycles, then 0x1000 for 3 cycles; exactly two ack[1] pulses; RAM holds 0xA and 0xB.
- Round-robin within a class: PRIO=4'b0101, req[0] and req[2] held continuously, single reads → grants alternate 0, 2, 0, 2, …
- Starvation: STARVE_LIMIT=3, req[0]/req[2] continuous, req[1] waiting → req[1] granted on its 4th arbitration; its counter then reads 0.
- Withdrawal and retry: ramstate=ERROR for 4 cycles during BEAT0 → outputs held and no ack. Then req dropped → RAM enables 0 next cycle and return to IDLE with no ack.
- Async reset in BEAT1 of a burst → all outputs 0 immediately; after release, the first grant searches from index 0.
